image_op_sequencer: RTL and testbench
=====================================

// Module: image_op_sequencer
// PURPOSE
//   Job scheduler in front of the image_read/image_write processing core. Queues operation
//   requests (opcode + parameter) and launches them one at a time on the single shared core.
//   For each job it pulses the start, counts written pixels against the frame size, waits
//   for the output file close, and flags timeouts and protocol errors.
// PARAMETERS
//   QDEPTH      4        job queue depth, power of two, >= 2
//   TIMEOUT     1000000  max cycles without a pix_strobe while RUN before declaring a stall
//   CNT_W       22       width of the pixel counter (covers 2047x2047 frames)
// PORTS
//   CLK          in   1      clock, all logic on rising edge
//   RESET        in   1      synchronous, active-high reset
//   job_valid    in   1      job request valid
//   job_ready    out  1      queue can accept (registered, = !full)
//   job_opcode   in   2      0 BRIGHTNESS, 1 GRAYSCALE, 2 ROTATE, 3 illegal
//   job_param    in   8      brightness delta (ignored for other opcodes)
//   core_start   out  1      one-cycle launch pulse to the core
//   core_opcode  out  2      opcode driven to the core, stable from start to job end
//   core_param   out  8      parameter driven to the core, stable like core_opcode
//   img_width    in   11     frame width reported by the core (sampled at start+1)
//   img_height   in   11     frame height reported by the core (sampled at start+1)
//   pix_strobe   in   1      one pulse per pixel written by the core
//   core_done    in   1      core finished streaming the frame (pulse)
//   file_closed  in   1      writer has closed the output file (level or pulse)
//   err_clear    in   1      clears sticky error flags and leaves ERROR
//   busy         out  1      high in any state other than IDLE
//   jobs_done    out  8      completed-job counter, wraps 255->0
//   err_opcode   out  1      sticky: illegal opcode was dropped at queue pop
//   err_count    out  1      sticky: core_done with pixel count != width*height
//   err_timeout  out  1      sticky: stall timeout fired
// BEHAVIOUR
//   Reset: queue empty, job_ready=1, FSM=IDLE, core_start=0, core_opcode=0, core_param=0,
//     busy=0, jobs_done=0, all err_* = 0. Reset mid-job abandons the job and empties the queue.
//   Queue: push when job_valid&&job_ready. job_ready is !full from the previous cycle, so a
//     push is refused while full even if a pop occurs in the same cycle. A push and a pop in
//     the same cycle on a non-full queue keep the count unchanged. FIFO order is strict.
//   FSM states:
//   IDLE:  if the queue is non-empty, pop the head. If the opcode is 3, set err_opcode, drop
//     the job, and stay in IDLE (the next pop happens the next cycle). Otherwise latch
//     core_opcode/core_param and go to START.
//   START: core_start=1 for exactly this cycle; clear the pixel counter and watchdog; go to SIZE.
//   SIZE:  latch total = img_width*img_height (22-bit, unsigned); go to RUN.
//   RUN:   each pix_strobe increments the count (saturates at all-ones) and clears the
//     watchdog. Otherwise the watchdog increments; when it reaches TIMEOUT, set err_timeout
//     and go to ERROR. On core_done, set err_count if count != total (include a strobe
//     coinciding with core_done in the count), then go to FLUSH.
//   FLUSH: wait for file_closed=1. The watchdog runs here too, and a timeout goes to ERROR.
//     On file_closed, increment jobs_done and go to IDLE. A next job can start the cycle
//     after IDLE is re-entered, giving a minimum 1 idle cycle between jobs.
//   ERROR: busy=1, no pops, core_start=0. On err_clear, clear all err_* and go to IDLE; the
//     queue is preserved. err_clear in another state clears flags only.
//   core_done or file_closed outside RUN/FLUSH are ignored. core_start never re-asserts
//     within a job.
// TESTING
//   1) Push op1 while idle, 4x2 frame, 8 strobes, core_done, then file_closed ->
//      core_start is high one cycle 2 clocks after the push; jobs_done=1; no errors.
//   2) Push 5 jobs back-to-back with QDEPTH=4 and the core stalled -> job_ready=0 after
//      the 4th push and the 5th is refused; jobs then execute in push order.
//   3) Push opcode 3 then opcode 1 -> err_opcode=1, the illegal job is dropped, the opcode-1
//      job starts, and jobs_done ends at 1.
//   4) 4x2 frame with only 7 strobes then core_done -> err_count=1, FLUSH is still
//      entered, and jobs_done increments on file_closed.
//   5) TIMEOUT=16 with no strobe in RUN -> err_timeout=1 at the 16th idle cycle, FSM in
//      ERROR; err_clear -> IDLE and the queued jobs resume.
//   6) Assert RESET during RUN with 2 jobs queued -> the next cycle shows busy=0,
//      job_ready=1, jobs_done=0, and no core_start afterwards.

Source files
------------

// File: rtl/image_op_sequencer.sv
// image_op_sequencer: job FIFO in front of the shared image core; launches one job at a time,
// checks the written pixel count against the frame size, waits for file close, flags stalls.
module image_op_sequencer #(
   parameter int QDEPTH  = 4,
   parameter int TIMEOUT = 1000000,
   parameter int CNT_W   = 22
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        job_valid,
   output logic        job_ready,
   input  logic [1:0]  job_opcode,
   input  logic [7:0]  job_param,
   output logic        core_start,
   output logic [1:0]  core_opcode,
   output logic [7:0]  core_param,
   input  logic [10:0] img_width,
   input  logic [10:0] img_height,
   input  logic        pix_strobe,
   input  logic        core_done,
   input  logic        file_closed,
   input  logic        err_clear,
   output logic        busy,
   output logic [7:0]  jobs_done,
   output logic        err_opcode,
   output logic        err_count,
   output logic        err_timeout
);
   localparam int AW   = $clog2(QDEPTH);
   localparam int WD_W = $clog2(TIMEOUT + 1);
   typedef enum logic [2:0] {S_IDLE, S_START, S_SIZE, S_RUN, S_FLUSH, S_ERROR} state_t;
   logic [9:0]       mem_q [QDEPTH];
   logic [9:0]       head;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             job_ready_q, job_ready_d, push, pop;
   state_t           state_q, state_d;
   logic             core_start_q, core_start_d, busy_q, busy_d;
   logic [1:0]       core_opcode_q, core_opcode_d;
   logic [7:0]       core_param_q, core_param_d, jobs_done_q, jobs_done_d;
   logic [CNT_W-1:0] pix_q, pix_d, pix_inc, total_q, total_d;
   logic [WD_W-1:0]  wd_q, wd_d, wd_inc;
   logic             err_opcode_q, err_opcode_d, err_count_q, err_count_d, err_timeout_q, err_timeout_d;
   always_comb begin
      push          = job_valid && job_ready_q;
      head          = mem_q[rd_ptr_q];
      pop           = 1'b0;
      state_d       = state_q;
      core_opcode_d = core_opcode_q;
      core_param_d  = core_param_q;
      jobs_done_d   = jobs_done_q;
      total_d       = total_q;
      pix_d         = pix_q;
      wd_d          = wd_q;
      pix_inc       = (pix_q == '1) ? pix_q : pix_q + CNT_W'(1);
      wd_inc        = pix_strobe ? '0 : wd_q + WD_W'(1);
      err_opcode_d  = err_clear ? 1'b0 : err_opcode_q;
      err_count_d   = err_clear ? 1'b0 : err_count_q;
      err_timeout_d = err_clear ? 1'b0 : err_timeout_q;
      case (state_q)
         S_IDLE: if (cnt_q != '0) begin
            pop = 1'b1;
            if (head[9:8] == 2'd3) err_opcode_d = 1'b1;
            else begin
               core_opcode_d = head[9:8];
               core_param_d  = head[7:0];
               state_d       = S_START;
            end
         end
         S_START: begin
            pix_d   = '0;
            wd_d    = '0;
            state_d = S_SIZE;
         end
         S_SIZE: begin
            total_d = CNT_W'(img_width) * CNT_W'(img_height);
            state_d = S_RUN;
         end
         S_RUN: begin
            pix_d = pix_strobe ? pix_inc : pix_q;
            wd_d  = wd_inc;
            if (core_done) begin
               err_count_d = err_count_d || (pix_d != total_q);
               state_d     = S_FLUSH;
            end else if (wd_inc == WD_W'(TIMEOUT)) begin
               err_timeout_d = 1'b1;
               state_d       = S_ERROR;
            end
         end
         S_FLUSH: begin
            wd_d = wd_inc;
            if (file_closed) begin
               jobs_done_d = jobs_done_q + 8'd1;
               state_d     = S_IDLE;
            end else if (wd_inc == WD_W'(TIMEOUT)) begin
               err_timeout_d = 1'b1;
               state_d       = S_ERROR;
            end
         end
         S_ERROR: state_d = err_clear ? S_IDLE : S_ERROR;
         default: state_d = S_IDLE;
      endcase
      wr_ptr_d     = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d     = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      cnt_d        = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      job_ready_d  = cnt_d != (AW+1)'(QDEPTH);
      core_start_d = state_d == S_START;
      busy_d       = state_d != S_IDLE;
   end
   always_ff @(posedge CLK) begin
      if (push) mem_q[wr_ptr_q] <= {job_opcode, job_param};
      if (RESET) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         cnt_q         <= '0;
         job_ready_q   <= 1'b1;
         state_q       <= S_IDLE;
         core_start_q  <= 1'b0;
         core_opcode_q <= '0;
         core_param_q  <= '0;
         busy_q        <= 1'b0;
         jobs_done_q   <= '0;
         total_q       <= '0;
         pix_q         <= '0;
         wd_q          <= '0;
         err_opcode_q  <= 1'b0;
         err_count_q   <= 1'b0;
         err_timeout_q <= 1'b0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         cnt_q         <= cnt_d;
         job_ready_q   <= job_ready_d;
         state_q       <= state_d;
         core_start_q  <= core_start_d;
         core_opcode_q <= core_opcode_d;
         core_param_q  <= core_param_d;
         busy_q        <= busy_d;
         jobs_done_q   <= jobs_done_d;
         total_q       <= total_d;
         pix_q         <= pix_d;
         wd_q          <= wd_d;
         err_opcode_q  <= err_opcode_d;
         err_count_q   <= err_count_d;
         err_timeout_q <= err_timeout_d;
      end
   end
   assign job_ready   = job_ready_q;
   assign core_start  = core_start_q;
   assign core_opcode = core_opcode_q;
   assign core_param  = core_param_q;
   assign busy        = busy_q;
   assign jobs_done   = jobs_done_q;
   assign err_opcode  = err_opcode_q;
   assign err_count   = err_count_q;
   assign err_timeout = err_timeout_q;
endmodule

// File: tb/tb_image_op_sequencer.sv
// tb_image_op_sequencer: vector table, hand-written corner sequences and randomized job batches
// checked against a job-level model of the sequencer.
module tb_image_op_sequencer;
   logic        CLK = 1'b0, RESET = 1'b1;
   logic        job_valid = 1'b0, job_ready;
   logic [1:0]  job_opcode = '0, core_opcode;
   logic [7:0]  job_param = '0, core_param, jobs_done;
   logic        core_start, pix_strobe = 1'b0, core_done = 1'b0, file_closed = 1'b0, err_clear = 1'b0;
   logic [10:0] img_width = '0, img_height = '0;
   logic        busy, err_opcode, err_count, err_timeout;
   int          total = 0, bad = 0, exp_jobs = 0;

   image_op_sequencer #(.QDEPTH(4), .TIMEOUT(16), .CNT_W(22)) dut (
      .CLK(CLK), .RESET(RESET), .job_valid(job_valid), .job_ready(job_ready),
      .job_opcode(job_opcode), .job_param(job_param), .core_start(core_start),
      .core_opcode(core_opcode), .core_param(core_param), .img_width(img_width),
      .img_height(img_height), .pix_strobe(pix_strobe), .core_done(core_done),
      .file_closed(file_closed), .err_clear(err_clear), .busy(busy), .jobs_done(jobs_done),
      .err_opcode(err_opcode), .err_count(err_count), .err_timeout(err_timeout)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running required finished");
      $fatal(1);
   end

   typedef struct {
      logic [1:0] op;
      logic [7:0] prm;
      int         w, h, ns;
      bit         co;
      int         exp_cnt_err, exp_op_err;
   } vec_t;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   task automatic push_job(input logic [1:0] op, input logic [7:0] prm, output bit ok);
      job_valid = 1'b1;
      job_opcode = op;
      job_param = prm;
      ok = job_ready;
      @(negedge CLK);
      job_valid = 1'b0;
   endtask

   task automatic clear_errs();
      err_clear = 1'b1;
      @(negedge CLK);
      err_clear = 1'b0;
   endtask

   task automatic wait_start(output bit seen);
      for (int i = 0; i < 60 && !core_start; i++) @(negedge CLK);
      seen = core_start;
   endtask

   // Plays the core: waits for the launch, then streams ns strobes, core_done, and file close.
   task automatic run_core(input logic [1:0] op, input logic [7:0] prm, input int w, input int h,
                           input int ns, input bit co, input int fw);
      bit seen;
      img_width = 11'(w);
      img_height = 11'(h);
      wait_start(seen);
      check("start_seen", int'(seen), 1);
      if (!seen) return;
      check("core_opcode", int'(core_opcode), int'(op));
      check("core_param", int'(core_param), int'(prm));
      @(negedge CLK);
      check("start_one_cycle", int'(core_start), 0);
      @(negedge CLK);
      check("busy_run", int'(busy), 1);
      for (int i = 0; i < ns; i++) begin
         pix_strobe = 1'b1;
         core_done = co && (i == ns - 1);
         @(negedge CLK);
      end
      pix_strobe = 1'b0;
      if (!(co && ns > 0)) begin
         core_done = 1'b1;
         @(negedge CLK);
      end
      core_done = 1'b0;
      repeat (fw) @(negedge CLK);
      check("opcode_stable", int'(core_opcode), int'(op));
      file_closed = 1'b1;
      @(negedge CLK);
      file_closed = 1'b0;
   endtask

   initial begin
      vec_t vecs[8];
      bit ok, seen;
      logic [1:0] qop[5];
      logic [7:0] qprm[5];
      vecs[0] = '{2'd1, 8'h00, 4, 2, 8, 1'b0, 0, 0};
      vecs[1] = '{2'd0, 8'h7f, 4, 2, 7, 1'b0, 1, 0};
      vecs[2] = '{2'd2, 8'h10, 4, 2, 9, 1'b0, 1, 0};
      vecs[3] = '{2'd0, 8'hff, 3, 5, 15, 1'b1, 0, 0};
      vecs[4] = '{2'd1, 8'h01, 0, 7, 0, 1'b0, 0, 0};
      vecs[5] = '{2'd2, 8'h22, 1, 1, 1, 1'b1, 0, 0};
      vecs[6] = '{2'd3, 8'h55, 2, 2, 4, 1'b0, 0, 1};
      vecs[7] = '{2'd0, 8'h80, 2, 3, 5, 1'b1, 1, 0};

      repeat (2) @(negedge CLK);
      RESET = 1'b0;
      check("rst_job_ready", int'(job_ready), 1);
      check("rst_busy", int'(busy), 0);
      check("rst_core_start", int'(core_start), 0);
      check("rst_core_opcode", int'(core_opcode), 0);
      check("rst_core_param", int'(core_param), 0);
      check("rst_jobs_done", int'(jobs_done), 0);
      check("rst_errs", int'({err_opcode, err_count, err_timeout}), 0);

      // Single job: launch two clocks after the push cycle.
      img_width = 11'd4;
      img_height = 11'd2;
      push_job(2'd1, 8'h3c, ok);
      check("t1_push_ok", int'(ok), 1);
      check("t1_no_start_yet", int'(core_start), 0);
      @(negedge CLK);
      check("t1_start_latency", int'(core_start), 1);
      run_core(2'd1, 8'h3c, 4, 2, 8, 1'b0, 2);
      exp_jobs++;
      check("t1_jobs_done", int'(jobs_done), exp_jobs);
      check("t1_errs", int'({err_opcode, err_count, err_timeout}), 0);
      check("t1_idle", int'(busy), 0);

      // Illegal opcode followed by a legal one.
      push_job(2'd3, 8'h11, ok);
      push_job(2'd1, 8'h22, ok);
      run_core(2'd1, 8'h22, 2, 2, 4, 1'b0, 0);
      exp_jobs++;
      check("t3_err_opcode", int'(err_opcode), 1);
      check("t3_jobs_done", int'(jobs_done), exp_jobs);
      clear_errs();
      check("t3_cleared", int'(err_opcode), 0);

      foreach (vecs[k]) begin
         push_job(vecs[k].op, vecs[k].prm, ok);
         if (vecs[k].op != 2'd3) begin
            run_core(vecs[k].op, vecs[k].prm, vecs[k].w, vecs[k].h, vecs[k].ns, vecs[k].co, 1);
            exp_jobs++;
         end else repeat (3) @(negedge CLK);
         check($sformatf("vec%0d_err_count", k), int'(err_count), vecs[k].exp_cnt_err);
         check($sformatf("vec%0d_err_opcode", k), int'(err_opcode), vecs[k].exp_op_err);
         check($sformatf("vec%0d_jobs_done", k), int'(jobs_done), exp_jobs);
         check($sformatf("vec%0d_idle", k), int'(busy), 0);
         clear_errs();
      end

      // Stall timeout, then fill the queue while in ERROR and resume after err_clear.
      push_job(2'd2, 8'h44, ok);
      wait_start(seen);
      check("t5_start", int'(seen), 1);
      repeat (17) @(negedge CLK);
      check("t5_no_timeout_yet", int'(err_timeout), 0);
      @(negedge CLK);
      check("t5_timeout", int'(err_timeout), 1);
      check("t5_busy_error", int'(busy), 1);
      for (int i = 0; i < 5; i++) begin
         qop[i] = 2'(i % 3);
         qprm[i] = 8'(8'hA0 + i);
         push_job(qop[i], qprm[i], ok);
         check($sformatf("t2_push%0d_accepted", i), int'(ok), (i < 4) ? 1 : 0);
      end
      check("t2_full_not_ready", int'(job_ready), 0);
      repeat (3) @(negedge CLK);
      check("t5_no_pop_in_error", int'(core_start), 0);
      check("t5_still_error", int'(err_timeout), 1);
      clear_errs();
      check("t5_cleared", int'(err_timeout), 0);
      check("t5_idle_after_clear", int'(busy), 0);
      for (int i = 0; i < 4; i++) begin
         run_core(qop[i], qprm[i], 1, 2, 2, 1'b0, 0);
         exp_jobs++;
      end
      check("t2_jobs_done", int'(jobs_done), exp_jobs);
      check("t2_fifo_empty_idle", int'(busy), 0);

      // Random batches checked against a job-level model.
      for (int b = 0; b < 30; b++) begin
         int n, nlegal;
         logic [1:0] rop[4];
         logic [7:0] rprm[4];
         int rw[4], rh[4], rns[4], rfw[4];
         bit rco[4];
         bit m_cnt, m_op;
         n = $urandom_range(1, 4);
         nlegal = 0;
         m_cnt = 1'b0;
         m_op = 1'b0;
         for (int i = 0; i < n; i++) begin
            int d;
            rop[i] = ($urandom_range(0, 3) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            rprm[i] = 8'($urandom);
            rw[i] = $urandom_range(0, 5);
            rh[i] = $urandom_range(0, 5);
            d = $urandom_range(0, 3);
            rns[i] = rw[i] * rh[i] + ((d == 0) ? -1 : (d == 3) ? 1 : 0);
            if (rns[i] < 0) rns[i] = 0;
            rco[i] = 1'($urandom_range(0, 1));
            rfw[i] = $urandom_range(0, 5);
            if (rop[i] == 2'd3) m_op = 1'b1;
            else begin
               nlegal++;
               if (rns[i] != rw[i] * rh[i]) m_cnt = 1'b1;
            end
         end
         fork
            begin
               bit pok;
               for (int i = 0; i < n; i++) begin
                  push_job(rop[i], rprm[i], pok);
                  check("rnd_push_ok", int'(pok), 1);
               end
            end
            begin
               for (int i = 0; i < n; i++)
                  if (rop[i] != 2'd3) run_core(rop[i], rprm[i], rw[i], rh[i], rns[i], rco[i], rfw[i]);
            end
         join
         repeat (3) @(negedge CLK);
         exp_jobs += nlegal;
         check("rnd_jobs_done", int'(jobs_done), exp_jobs % 256);
         check("rnd_err_count", int'(err_count), int'(m_cnt));
         check("rnd_err_opcode", int'(err_opcode), int'(m_op));
         check("rnd_err_timeout", int'(err_timeout), 0);
         check("rnd_idle", int'(busy), 0);
         clear_errs();
      end

      // Reset in the middle of a run with two jobs waiting.
      img_width = 11'd4;
      img_height = 11'd4;
      push_job(2'd1, 8'h09, ok);
      wait_start(seen);
      check("t6_start", int'(seen), 1);
      push_job(2'd2, 8'h0a, ok);
      push_job(2'd0, 8'h0b, ok);
      pix_strobe = 1'b1;
      repeat (2) @(negedge CLK);
      pix_strobe = 1'b0;
      RESET = 1'b1;
      @(negedge CLK);
      RESET = 1'b0;
      check("t6_busy", int'(busy), 0);
      check("t6_job_ready", int'(job_ready), 1);
      check("t6_jobs_done", int'(jobs_done), 0);
      check("t6_core_opcode", int'(core_opcode), 0);
      begin
         int starts = 0;
         for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (core_start) starts++;
         end
         check("t6_no_start_after_reset", starts, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
